mem_wb_multi: RTL and testbench
===============================

Name: mem_wb_multi

Overview:
- Parametrised MEM/WB pipeline register, next generation of the single-issue version.
- Carries NUM_CH independent GPR write channels plus HI/LO and LLbit side-channels, with stall-bubble, flush and per-stage valid tracking.
- Also provides saturating retire/bubble event counters.
- Sits between the memory-access stage and the register file / HILO / LLbit writers; WB-side outputs also feed the forwarding network.

Parameters:
- DATA_W, 32, width of each GPR write datum and of HI/LO.
- ADDR_W, 5, GPR address width.
- NUM_CH, 2, number of GPR write channels (1..4); channel index = program order, higher index is younger.
- STALL_W, 6, width of the global stall vector.
- STAGE_IDX, 4, this stage's bit in the stall vector; STAGE_IDX+1 is the downstream bit, so STAGE_IDX+1 < STALL_W.
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  STALL_W  global stall vector; 1 = stop.
- flush  in  1  exception flush; kills the incoming instruction.
- cnt_clr  in  1  synchronous clear of both counters.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_wreg  in  NUM_CH  per-channel GPR write enable.
- mem_wd  in  NUM_CH*ADDR_W  per-channel destination address, channel 0 in the LSBs.
- mem_wdata  in  NUM_CH*DATA_W  per-channel write data.
- mem_whilo  in  1  HI/LO write enable.
- mem_hi, mem_lo  in  DATA_W each  HI/LO values.
- mem_LLbit_we  in  1  LLbit write enable.
- mem_LLbit_value  in  1  LLbit value.
- wb_valid  out  1  registered valid.
- wb_wreg, wb_wd, wb_wdata  out  same widths as inputs  registered channels.
- wb_whilo, wb_hi, wb_lo, wb_LLbit_we, wb_LLbit_value  out  registered side-channels.
- retire_cnt  out  CNT_W  count of valid instructions advanced into WB.
- bubble_cnt  out  CNT_W  count of bubbles inserted.

Behaviour:
- Reset is synchronous, active-high on rst. During a reset cycle:
  - all wb_* outputs go to 0 (write enables = WriteDisable, wb_wd = NOPRegAddr, data = ZeroWord);
  - both counters go to 0.
- Per-edge priority, highest first:
  1. rst
  2. flush
  3. bubble: stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0
  4. advance: stall[STAGE_IDX]=0
  5. hold: stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=1, all outputs keep their value
- Flush and bubble both load the reset values into every wb_* output (valid = 0).
- Advance loads the inputs with one-cycle latency, applying:
  - wb_valid <= mem_valid.
  - If mem_valid = 0, every write enable is forced to 0; address and data still load.
  - Same-cycle collision merge: if channels i < j both have wreg = 1 and equal nonzero address, wb_wreg[i] <= 0. The youngest writer wins. Data is still captured unchanged.
  - Any write to address 0 passes through; the register file ignores it.
- retire_cnt increments on an advance edge with mem_valid = 1 and flush = 0.
- bubble_cnt increments on flush edges and on bubble edges.
- Both counters saturate at 2^CNT_W-1 with no wrap.
- cnt_clr zeroes both counters and takes priority over increments in the same cycle. rst overrides cnt_clr.
- Reset mid-stall: rst wins; after reset is released, behaviour depends only on the current stall and flush inputs.
- There is no combinational path from any input to any wb_* output or counter.

Decomposition:
- Shared package/defines:
  - RstEnable, WriteDisable, Stop/NoStop, ZeroWord, NOPRegAddr (existing);
  - new STALL_W default and per-stage STAGE_IDX constants (IF..WB = 0..5).
- One sub-module, wb_sat_counter (CNT_W width; inc/clr inputs; saturating). It is instantiated twice.
- The collision merge is a generate loop in the top module.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all inputs nonzero -> all outputs 0, counters 0. Release with stall=6'b0 and mem_valid=1, wd0=3, wdata0=32'hDEADBEEF, wreg=2'b01 -> next edge: wb_wd0=3, wb_wdata0=DEADBEEF, retire_cnt=1.
- Bubble vs. hold:
  - stall=6'b011111 -> outputs zeroed, bubble_cnt +1, wb_valid=0.
  - stall=6'b111111 for 3 cycles -> outputs unchanged, no counter change.
- Collision merge: wreg=2'b11, wd0=wd1=5, wdata0=1, wdata1=2 -> wb_wreg=2'b10, wb_wdata1=2.
  - Same stimulus with wd0=wd1=0 -> wb_wreg=2'b11.
- Flush priority: flush=1 with stall=0, mem_valid=1, whilo=1, hi=7 -> wb_whilo=0, wb_hi=0, bubble_cnt +1, retire_cnt unchanged.
- Invalid squash: mem_valid=0, wreg=2'b11, LLbit_we=1 on an advance -> all write enables 0, wb_valid=0, retire_cnt unchanged.
- Counter saturation and clear: CNT_W=4, 20 valid advances -> retire_cnt=15. cnt_clr=1 asserted together with a valid advance -> retire_cnt=0.

Source files
------------

// File: rtl/mem_wb_multi_pkg.sv
// Shared constants and helpers for the multi-channel MEM/WB pipeline register.
package mem_wb_multi_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    // Global stall vector layout: one bit per pipeline stage.
    localparam int STALL_W_DEF = 6;
    localparam int STAGE_IF    = 0;
    localparam int STAGE_ID    = 1;
    localparam int STAGE_EX    = 2;
    localparam int STAGE_EX2   = 3;
    localparam int STAGE_MEM   = 4;
    localparam int STAGE_WB    = 5;

    // What the register does on the next rising edge (reset handled separately).
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_ADVANCE = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } wb_action_e;

    // Flush beats bubble, bubble beats advance, otherwise hold.
    function automatic wb_action_e decode_action(input logic flush,
                                                 input logic stall_self,
                                                 input logic stall_next);
        if (flush)
            return ACT_FLUSH;
        else if (stall_self == Stop && stall_next == NoStop)
            return ACT_BUBBLE;
        else if (stall_self == NoStop)
            return ACT_ADVANCE;
        else
            return ACT_HOLD;
    endfunction

endpackage

// File: rtl/mem_wb_multi_wb_sat_counter.sv
// Saturating event counter with synchronous clear; never wraps.
module wb_sat_counter
    import mem_wb_multi_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Reset and clear zero the count; increments stop at all-ones.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || clr) begin
            cnt <= '0;
        end else if (inc && cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_wb_multi.sv
// MEM/WB pipeline register with NUM_CH GPR write channels, HI/LO and LLbit
// side-channels, stall bubbles, flush and retire/bubble event counters.
module mem_wb_multi
    import mem_wb_multi_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_CH    = 2,
    parameter int STALL_W   = STALL_W_DEF,
    parameter int STAGE_IDX = STAGE_MEM,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic                     cnt_clr,
    input  logic                     mem_valid,
    input  logic [NUM_CH-1:0]        mem_wreg,
    input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
    input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
    input  logic                     mem_whilo,
    input  logic [DATA_W-1:0]        mem_hi,
    input  logic [DATA_W-1:0]        mem_lo,
    input  logic                     mem_LLbit_we,
    input  logic                     mem_LLbit_value,
    output logic                     wb_valid,
    output logic [NUM_CH-1:0]        wb_wreg,
    output logic [NUM_CH*ADDR_W-1:0] wb_wd,
    output logic [NUM_CH*DATA_W-1:0] wb_wdata,
    output logic                     wb_whilo,
    output logic [DATA_W-1:0]        wb_hi,
    output logic [DATA_W-1:0]        wb_lo,
    output logic                     wb_LLbit_we,
    output logic                     wb_LLbit_value,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);

    wb_action_e        action;
    logic [NUM_CH-1:0] wreg_merged;
    logic              retire_inc;
    logic              bubble_inc;
    logic              stall_unused;

    // Only this stage's bit and the downstream bit matter here.
    assign stall_unused = ^stall;

    // Decode the edge action from this stage's and the downstream stall bit.
    always_comb begin
        action = decode_action(flush, stall[STAGE_IDX], stall[STAGE_IDX+1]);
    end

    // Collision merge: an older channel's write is dropped when a younger
    // channel writes the same nonzero address; invalid slots write nothing.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_merge
        logic younger_hit;

        // Look for any younger channel targeting the same nonzero register.
        always_comb begin
            younger_hit = 1'b0;
            for (int j = i + 1; j < NUM_CH; j++) begin
                if (mem_wreg[j] &&
                    mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W] &&
                    mem_wd[i*ADDR_W +: ADDR_W] != '0) begin
                    younger_hit = 1'b1;
                end
            end
        end

        assign wreg_merged[i] = mem_valid & mem_wreg[i] & ~younger_hit;
    end

    // Pipeline register: reset/flush/bubble load zeros, advance loads inputs.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || action == ACT_FLUSH || action == ACT_BUBBLE) begin
            wb_valid       <= 1'b0;
            wb_wreg        <= {NUM_CH{WriteDisable}};
            wb_wd          <= '0;
            wb_wdata       <= '0;
            wb_whilo       <= WriteDisable;
            wb_hi          <= '0;
            wb_lo          <= '0;
            wb_LLbit_we    <= WriteDisable;
            wb_LLbit_value <= 1'b0;
        end else if (action == ACT_ADVANCE) begin
            wb_valid       <= mem_valid;
            wb_wreg        <= wreg_merged;
            wb_wd          <= mem_wd;
            wb_wdata       <= mem_wdata;
            wb_whilo       <= mem_whilo & mem_valid;
            wb_hi          <= mem_hi;
            wb_lo          <= mem_lo;
            wb_LLbit_we    <= mem_LLbit_we & mem_valid;
            wb_LLbit_value <= mem_LLbit_value;
        end
    end

    // Counter events; flush already wins over advance inside decode_action.
    assign retire_inc = (action == ACT_ADVANCE) && mem_valid;
    assign bubble_inc = (action == ACT_FLUSH) || (action == ACT_BUBBLE);

    wb_sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (retire_inc),
        .cnt (retire_cnt)
    );

    wb_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (bubble_inc),
        .cnt (bubble_cnt)
    );

endmodule

// File: tb/tb_mem_wb_multi.sv
// Self-checking bench for mem_wb_multi (NUM_CH=2, CNT_W=4 so saturation is reachable).
module tb_mem_wb_multi;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_CH  = 2;
    localparam int STALL_W = 6;
    localparam int CNT_W   = 4;
    localparam int EXP_W   = 1 + NUM_CH + NUM_CH*ADDR_W + NUM_CH*DATA_W + 1 + 2*DATA_W + 2 + 2*CNT_W;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic [STALL_W-1:0]       stall;
    logic                     flush;
    logic                     cnt_clr;
    logic                     mem_valid;
    logic [NUM_CH-1:0]        mem_wreg;
    logic [NUM_CH*ADDR_W-1:0] mem_wd;
    logic [NUM_CH*DATA_W-1:0] mem_wdata;
    logic                     mem_whilo;
    logic [DATA_W-1:0]        mem_hi;
    logic [DATA_W-1:0]        mem_lo;
    logic                     mem_LLbit_we;
    logic                     mem_LLbit_value;
    logic                     wb_valid;
    logic [NUM_CH-1:0]        wb_wreg;
    logic [NUM_CH*ADDR_W-1:0] wb_wd;
    logic [NUM_CH*DATA_W-1:0] wb_wdata;
    logic                     wb_whilo;
    logic [DATA_W-1:0]        wb_hi;
    logic [DATA_W-1:0]        wb_lo;
    logic                     wb_LLbit_we;
    logic                     wb_LLbit_value;
    logic [CNT_W-1:0]         retire_cnt;
    logic [CNT_W-1:0]         bubble_cnt;

    mem_wb_multi #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
        .STALL_W(STALL_W), .STAGE_IDX(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd),
        .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_LLbit_we(mem_LLbit_we),
        .mem_LLbit_value(mem_LLbit_value),
        .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_wd(wb_wd),
        .wb_wdata(wb_wdata), .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
        .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Reference model state (what WB should hold after each edge)
    logic                     m_valid;
    logic [NUM_CH-1:0]        m_wreg;
    logic [NUM_CH*ADDR_W-1:0] m_wd;
    logic [NUM_CH*DATA_W-1:0] m_wdata;
    logic                     m_whilo;
    logic [DATA_W-1:0]        m_hi;
    logic [DATA_W-1:0]        m_lo;
    logic                     m_llwe;
    logic                     m_llval;
    logic [CNT_W-1:0]         m_retire;
    logic [CNT_W-1:0]         m_bubble;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Compute the expected post-edge state from the current inputs and push it.
    task automatic model_and_push();
        logic [NUM_CH-1:0] nw;
        logic bub;
        logic adv;
        if (rst) begin
            m_valid = 0; m_wreg = 0; m_wd = 0; m_wdata = 0; m_whilo = 0;
            m_hi = 0; m_lo = 0; m_llwe = 0; m_llval = 0; m_retire = 0; m_bubble = 0;
        end else begin
            bub = flush || (stall[4] && !stall[5]);
            adv = !flush && !stall[4];
            if (bub) begin
                m_valid = 0; m_wreg = 0; m_wd = 0; m_wdata = 0; m_whilo = 0;
                m_hi = 0; m_lo = 0; m_llwe = 0; m_llval = 0;
            end else if (adv) begin
                nw = mem_wreg;
                for (int i = 0; i < NUM_CH; i++)
                    for (int j = i + 1; j < NUM_CH; j++)
                        if (mem_wreg[i] && mem_wreg[j] &&
                            mem_wd[i*ADDR_W +: ADDR_W] == mem_wd[j*ADDR_W +: ADDR_W] &&
                            mem_wd[i*ADDR_W +: ADDR_W] != 5'd0)
                            nw[i] = 1'b0;
                if (!mem_valid) nw = '0;
                m_valid = mem_valid;
                m_wreg  = nw;
                m_wd    = mem_wd;
                m_wdata = mem_wdata;
                m_whilo = mem_whilo && mem_valid;
                m_hi    = mem_hi;
                m_lo    = mem_lo;
                m_llwe  = mem_LLbit_we && mem_valid;
                m_llval = mem_LLbit_value;
            end
            if (cnt_clr) begin
                m_retire = 0;
                m_bubble = 0;
            end else begin
                if (adv && mem_valid) m_retire = sat_inc(m_retire);
                if (bub) m_bubble = sat_inc(m_bubble);
            end
        end
        exp_q.push_back({m_valid, m_wreg, m_wd, m_wdata, m_whilo, m_hi, m_lo,
                         m_llwe, m_llval, m_retire, m_bubble});
    endtask

    // Pop one expected record and compare every output against it.
    task automatic compare_outputs();
        logic [EXP_W-1:0]         e;
        logic                     e_valid;
        logic [NUM_CH-1:0]        e_wreg;
        logic [NUM_CH*ADDR_W-1:0] e_wd;
        logic [NUM_CH*DATA_W-1:0] e_wdata;
        logic                     e_whilo;
        logic [DATA_W-1:0]        e_hi;
        logic [DATA_W-1:0]        e_lo;
        logic                     e_llwe;
        logic                     e_llval;
        logic [CNT_W-1:0]         e_retire;
        logic [CNT_W-1:0]         e_bubble;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        {e_valid, e_wreg, e_wd, e_wdata, e_whilo, e_hi, e_lo,
         e_llwe, e_llval, e_retire, e_bubble} = e;
        check("wb_valid",   64'(wb_valid),       64'(e_valid));
        check("wb_wreg",    64'(wb_wreg),        64'(e_wreg));
        check("wb_wd",      64'(wb_wd),          64'(e_wd));
        check("wb_wdata",   wb_wdata,            e_wdata);
        check("wb_whilo",   64'(wb_whilo),       64'(e_whilo));
        check("wb_hi",      64'(wb_hi),          64'(e_hi));
        check("wb_lo",      64'(wb_lo),          64'(e_lo));
        check("wb_llwe",    64'(wb_LLbit_we),    64'(e_llwe));
        check("wb_llval",   64'(wb_LLbit_value), 64'(e_llval));
        check("retire_cnt", 64'(retire_cnt),     64'(e_retire));
        check("bubble_cnt", 64'(bubble_cnt),     64'(e_bubble));
    endtask

    // ---------------- driver tasks ----------------
    // One clock: predict, let the edge happen, compare 1 ns later.
    task automatic step();
        model_and_push();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic set_inputs(input logic [5:0] st, input logic fl, input logic v,
                              input logic [1:0] wr, input logic [4:0] wd1, input logic [4:0] wd0,
                              input logic [31:0] d1, input logic [31:0] d0);
        stall     = st;
        flush     = fl;
        mem_valid = v;
        mem_wreg  = wr;
        mem_wd    = {wd1, wd0};
        mem_wdata = {d1, d0};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [CNT_W-1:0] bub_before;
        logic [CNT_W-1:0] ret_before;

        // Reset with every input nonzero
        rst = 1'b1; cnt_clr = 1'b1;
        set_inputs(6'b111111, 1'b1, 1'b1, 2'b11, 5'd9, 5'd9, 32'h1111_1111, 32'h2222_2222);
        mem_whilo = 1'b1; mem_hi = 32'h33; mem_lo = 32'h44;
        mem_LLbit_we = 1'b1; mem_LLbit_value = 1'b1;
        step();
        step();
        check("rst_valid", 64'(wb_valid), 64'd0);
        check("rst_retire", 64'(retire_cnt), 64'd0);

        // Release: first valid advance
        rst = 1'b0; cnt_clr = 1'b0;
        mem_whilo = 1'b0; mem_LLbit_we = 1'b0; mem_LLbit_value = 1'b0;
        set_inputs(6'b000000, 1'b0, 1'b1, 2'b01, 5'd0, 5'd3, 32'h0, 32'hDEAD_BEEF);
        step();
        check("first_wd0", 64'(wb_wd[4:0]), 64'd3);
        check("first_wdata0", 64'(wb_wdata[31:0]), 64'hDEAD_BEEF);
        check("first_retire", 64'(retire_cnt), 64'd1);

        // Bubble
        set_inputs(6'b011111, 1'b0, 1'b1, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6);
        step();
        check("bubble_valid", 64'(wb_valid), 64'd0);
        check("bubble_cnt1", 64'(bubble_cnt), 64'd1);

        // Load known data, then hold 3 cycles with changing inputs
        set_inputs(6'b000000, 1'b0, 1'b1, 2'b01, 5'd0, 5'd7, 32'h0, 32'hAAAA_5555);
        step();
        for (int k = 0; k < 3; k++) begin
            set_inputs(6'b111111, 1'b0, 1'b1, 2'b11, 5'(k + 10), 5'(k + 20), 32'(k), 32'(k + 100));
            step();
            check("hold_wdata0", 64'(wb_wdata[31:0]), 64'hAAAA_5555);
            check("hold_bubble", 64'(bubble_cnt), 64'd1);
        end

        // Collision merge on a nonzero address, then on address 0
        set_inputs(6'b000000, 1'b0, 1'b1, 2'b11, 5'd5, 5'd5, 32'd2, 32'd1);
        step();
        check("merge_wreg", 64'(wb_wreg), 64'b10);
        check("merge_wdata1", 64'(wb_wdata[63:32]), 64'd2);
        set_inputs(6'b000000, 1'b0, 1'b1, 2'b11, 5'd0, 5'd0, 32'd2, 32'd1);
        step();
        check("zero_addr_wreg", 64'(wb_wreg), 64'b11);

        // Flush beats advance
        bub_before = m_bubble; ret_before = m_retire;
        set_inputs(6'b000000, 1'b1, 1'b1, 2'b11, 5'd4, 5'd6, 32'd8, 32'd9);
        mem_whilo = 1'b1; mem_hi = 32'd7;
        step();
        check("flush_whilo", 64'(wb_whilo), 64'd0);
        check("flush_hi", 64'(wb_hi), 64'd0);
        check("flush_bubble", 64'(bubble_cnt), 64'(sat_inc(bub_before)));
        check("flush_retire", 64'(retire_cnt), 64'(ret_before));

        // Invalid slot squashes every write enable
        ret_before = m_retire;
        set_inputs(6'b000000, 1'b0, 1'b0, 2'b11, 5'd4, 5'd6, 32'd8, 32'd9);
        mem_whilo = 1'b1; mem_LLbit_we = 1'b1; mem_LLbit_value = 1'b1;
        step();
        check("squash_wreg", 64'(wb_wreg), 64'd0);
        check("squash_whilo", 64'(wb_whilo), 64'd0);
        check("squash_llwe", 64'(wb_LLbit_we), 64'd0);
        check("squash_valid", 64'(wb_valid), 64'd0);
        check("squash_retire", 64'(retire_cnt), 64'(ret_before));

        // Randomised traffic, small address range to provoke collisions
        for (int k = 0; k < 60; k++) begin
            rst       = ($urandom_range(0, 31) == 0);
            cnt_clr   = ($urandom_range(0, 15) == 0);
            set_inputs(6'($urandom_range(0, 63)), ($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       $urandom, $urandom);
            mem_whilo       = 1'($urandom_range(0, 1));
            mem_hi          = $urandom;
            mem_lo          = $urandom;
            mem_LLbit_we    = 1'($urandom_range(0, 1));
            mem_LLbit_value = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0;

        // Saturation: clear, then 20 valid advances
        cnt_clr = 1'b1;
        set_inputs(6'b000000, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        step();
        cnt_clr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_inputs(6'b000000, 1'b0, 1'b1, 2'b01, 5'd0, 5'(k + 1), 32'd0, 32'(k));
            step();
        end
        check("sat_retire", 64'(retire_cnt), 64'd15);
        check("sat_bubble", 64'(bubble_cnt), 64'd0);

        // Clear wins over an increment in the same cycle
        cnt_clr = 1'b1;
        step();
        check("clr_retire", 64'(retire_cnt), 64'd0);
        cnt_clr = 1'b0;

        // Reset in the middle of a hold
        set_inputs(6'b000000, 1'b0, 1'b1, 2'b11, 5'd2, 5'd1, 32'hB, 32'hA);
        step();
        set_inputs(6'b111111, 1'b0, 1'b1, 2'b11, 5'd2, 5'd1, 32'hB, 32'hA);
        rst = 1'b1;
        step();
        check("rst_hold_wreg", 64'(wb_wreg), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_hold_valid", 64'(wb_valid), 64'd0);
        stall = 6'b000000;
        step();
        check("post_rst_adv_wreg", 64'(wb_wreg), 64'b11);

        // Final report
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
